memshare_rqst_serializer: RTL

//  Consumes each SHARE_GROUP_SIZE-bit request-flag vector from the memShare skid-buffer stage.

---
 rtl/memshare_pkg.sv | 26 ++
 rtl/memshare_rr_pick.sv | 49 ++++
 rtl/memshare_rqst_serializer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/memshare_pkg.sv
// ----------------------------------------------------------------------------
// memshare_pkg
//   Shared types and constants for the memShare request serializer.
//   - memshare_ser_state_t : serializer FSM state encoding (IDLE / SERVE)
//   - idx_w()              : width of a requestor index for an N-wide share group
//   - SHARE_GROUP_SIZE_DEF / COL_ADDR_W_DEF : default group size and tag width
//   - STAT_W               : width of the optional grant/stall statistics counters
//   Optional feature macro used by the top level: MEMSHARE_SERIALIZER_STATS_EN
// ----------------------------------------------------------------------------
package memshare_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } memshare_ser_state_t;

  localparam int SHARE_GROUP_SIZE_DEF = 5;
  localparam int COL_ADDR_W_DEF       = 8;
  localparam int STAT_W               = 16;

  // Index width for n requestors; a 2-member group still needs one bit.
  function automatic int idx_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/memshare_rr_pick.sv
// ----------------------------------------------------------------------------
// memshare_rr_pick
//   Combinational round-robin picker. Finds the first set bit of `pending`
//   searching rr_ptr, rr_ptr+1, ... with wrap modulo N. Implemented as a
//   rotate by rr_ptr, a lowest-bit priority encode, and an un-rotate mod N.
// Ports
//   pending [N]      in   outstanding request flags
//   rr_ptr  [IDX_W]  in   search start position (expected < N)
//   idx     [IDX_W]  out  selected requestor index
//   last             out  exactly one flag remains in pending
// ----------------------------------------------------------------------------
module memshare_rr_pick
  import memshare_pkg::*;
#(
  parameter int N     = SHARE_GROUP_SIZE_DEF,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [N-1:0] rot;
  int           base;
  int           off;

  always_comb begin
    rot  = '0;
    base = 0;
    off  = 0;
    // rr_ptr never leaves 0..N-1 in operation; fold anything else to 0.
    if (int'(rr_ptr) < N) begin
      base = int'(rr_ptr);
    end
    for (int i = 0; i < N; i++) begin
      rot[i] = pending[(base + i) % N];
    end
    // Scan downward so the lowest set position wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = i;
      end
    end
    idx  = IDX_W'((base + off) % N);
    last = ($countones(pending) == 1);
  end

endmodule

// File: rtl/memshare_rqst_serializer.sv
// ----------------------------------------------------------------------------
// memshare_rqst_serializer
//   Takes N-bit request-flag vectors from the memShare skid-buffer stage and
//   serialises the set flags into one grant per cycle for the shared memory
//   port. Each grant carries the requestor index (the shift-ctrl value) and
//   the column-address tag of its vector. Round-robin order persists across
//   vectors; rr_ptr is only cleared by rst.
// Ports
//   sys_clk, rst                 clock (rising edge), async active-high reset
//   share_rqstFlag_i, colAddr_i  request vector and its tag
//   rqst_valid_i / rqst_ready_o  vector handshake
//   grant_valid_o / grant_ready_i grant handshake
//   grant_idx_o, grant_colAddr_o, grant_last_o  grant payload
//   busy_o                       FSM is in SERVE (state visibility)
//   grant_cnt_o, stall_cnt_o     saturating statistics, present only when
//                                MEMSHARE_SERIALIZER_STATS_EN is defined
//
// Handshake rule (both interfaces): a transfer happens on a rising sys_clk
// edge where valid and ready are both 1. While grant_valid_o is 1 the grant
// payload is held unchanged until grant_ready_i is 1. In SERVE, rqst_ready_o
// is combinationally grant_last_o & grant_ready_i so a new vector can load in
// the same cycle the previous vector's last grant leaves (no bubble).
// ----------------------------------------------------------------------------
module memshare_rqst_serializer
  import memshare_pkg::*;
#(
  parameter  int SHARE_GROUP_SIZE = SHARE_GROUP_SIZE_DEF,
  parameter  int COL_ADDR_W       = COL_ADDR_W_DEF,
  localparam int IDX_W            = idx_w(SHARE_GROUP_SIZE)
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic [SHARE_GROUP_SIZE-1:0] share_rqstFlag_i,
  input  logic [COL_ADDR_W-1:0]       colAddr_i,
  input  logic                        rqst_valid_i,
  output logic                        rqst_ready_o,
  output logic                        grant_valid_o,
  input  logic                        grant_ready_i,
  output logic [IDX_W-1:0]            grant_idx_o,
  output logic [COL_ADDR_W-1:0]       grant_colAddr_o,
  output logic                        grant_last_o,
  output logic                        busy_o
`ifdef MEMSHARE_SERIALIZER_STATS_EN
  ,
  output logic [STAT_W-1:0]           grant_cnt_o,
  output logic [STAT_W-1:0]           stall_cnt_o
`endif
);

  localparam int N = SHARE_GROUP_SIZE;

  memshare_ser_state_t state_q, state_d;
  logic [N-1:0]          pending_q;
  logic [COL_ADDR_W-1:0] tag_q;
  logic [IDX_W-1:0]      rr_ptr_q;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_last;
  logic [N-1:0]     clr_mask;
  logic             grant_xfer;
  logic             rqst_xfer;
  logic             flags_nz;

  memshare_rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .pending (pending_q),
    .rr_ptr  (rr_ptr_q),
    .idx     (pick_idx),
    .last    (pick_last)
  );

  assign grant_xfer = grant_valid_o & grant_ready_i;
  assign rqst_xfer  = rqst_valid_i & rqst_ready_o;
  assign flags_nz   = |share_rqstFlag_i;

  // State register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; any unexpected encoding behaves as IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SERVE: begin
        if (grant_xfer && pick_last) begin
          state_d = (rqst_xfer && flags_nz) ? SERVE : IDLE;
        end
      end
      default: begin
        state_d = (rqst_xfer && flags_nz) ? SERVE : IDLE;
      end
    endcase
  end

  // Output logic; rqst_ready_o is held low for as long as rst is high.
  always_comb begin
    rqst_ready_o    = 1'b0;
    grant_valid_o   = 1'b0;
    grant_idx_o     = '0;
    grant_colAddr_o = '0;
    grant_last_o    = 1'b0;
    busy_o          = 1'b0;
    case (state_q)
      SERVE: begin
        grant_valid_o   = 1'b1;
        grant_idx_o     = pick_idx;
        grant_colAddr_o = tag_q;
        grant_last_o    = pick_last;
        busy_o          = 1'b1;
        rqst_ready_o    = pick_last & grant_ready_i & ~rst;
      end
      default: begin
        rqst_ready_o = ~rst;
      end
    endcase
  end

  // One-hot mask of the flag being granted this cycle.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N; i++) begin
      clr_mask[i] = (pick_idx == IDX_W'(i));
    end
  end

  // A new vector only arrives when pending is empty or on its last grant,
  // so loading it overrides the clear of the outgoing flag.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      tag_q     <= '0;
      rr_ptr_q  <= '0;
    end else begin
      if (rqst_xfer) begin
        pending_q <= share_rqstFlag_i;
        tag_q     <= colAddr_i;
      end else if (grant_xfer) begin
        pending_q <= pending_q & ~clr_mask;
      end
      if (grant_xfer) begin
        rr_ptr_q <= (pick_idx == IDX_W'(N - 1)) ? '0 : pick_idx + IDX_W'(1);
      end
    end
  end

`ifdef MEMSHARE_SERIALIZER_STATS_EN
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      grant_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (grant_xfer && (grant_cnt_o != '1)) begin
        grant_cnt_o <= grant_cnt_o + STAT_W'(1);
      end
      if (grant_valid_o && !grant_ready_i && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + STAT_W'(1);
      end
    end
  end
`endif

endmodule
